// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU.
// Grants one requester per cycle (round-robin or fixed priority), registers
// the ALU result into a single-entry response slot, and counts accepted
// operations per requester with saturating counters.
module alu_arbiter #(
    parameter int unsigned RR_EN = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opselect,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [4:0]       req0_shamt,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opselect,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [4:0]       req1_shamt,

    output logic [3:0]       alu_opselect,
    output logic [31:0]      alu_x,
    output logic [31:0]      alu_y,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_res,
    input  logic             alu_v,
    input  logic             alu_c_out,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_res,
    output logic             rsp_v,
    output logic             rsp_c_out,
    output logic             rsp_zero,

    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_res_q, rsp_res_d;
    logic              rsp_v_q, rsp_v_d;
    logic              rsp_c_out_q, rsp_c_out_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic can_accept;
    logic gnt0, gnt1;
    logic accept;

    // Grant selection; depends only on valids, slot state and rsp_ready.
    always_comb begin
        can_accept = (state_q == StEmpty) | rsp_ready;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                if (RR_EN != 0) begin
                    // Alternate away from whoever won last.
                    if (last_grant_q) gnt0 = 1'b1;
                    else              gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
        accept = gnt0 | gnt1;
    end

    // Route the granted operation to the ALU; all zeros when idle.
    always_comb begin
        alu_opselect = 4'd0;
        alu_x        = 32'd0;
        alu_y        = 32'd0;
        alu_shamt    = 5'd0;
        if (gnt0) begin
            alu_opselect = req0_opselect;
            alu_x        = req0_x;
            alu_y        = req0_y;
            alu_shamt    = req0_shamt;
        end else if (gnt1) begin
            alu_opselect = req1_opselect;
            alu_x        = req1_x;
            alu_y        = req1_y;
            alu_shamt    = req1_shamt;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    // Slot next-state: fill on accept, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (!accept && rsp_ready) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Slot outputs.
    always_comb begin
        rsp_valid  = (state_q == StFull);
        req0_ready = gnt0;
        req1_ready = gnt1;
        rsp_id     = rsp_id_q;
        rsp_res    = rsp_res_q;
        rsp_v      = rsp_v_q;
        rsp_c_out  = rsp_c_out_q;
        rsp_zero   = rsp_zero_q;
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
    end

    // Response payload, last grant and saturating counters next-state.
    always_comb begin
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_v_d      = rsp_v_q;
        rsp_c_out_d  = rsp_c_out_q;
        rsp_zero_d   = rsp_zero_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (accept) begin
            rsp_id_d     = gnt1;
            rsp_res_d    = alu_res;
            rsp_v_d      = alu_v;
            rsp_c_out_d  = alu_c_out;
            rsp_zero_d   = alu_zero;
            last_grant_d = gnt1;
        end
        if (gnt0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
        if (gnt1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
    end

    // Payload and counter registers; last_grant resets to 1 so req0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= 32'd0;
            rsp_v_q      <= 1'b0;
            rsp_c_out_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_v_q      <= rsp_v_d;
            rsp_c_out_q  <= rsp_c_out_d;
            rsp_zero_q   <= rsp_zero_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

endmodule
